// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer scan-out path.
package fb_pkg;

    // Native framebuffer geometry (160x120, one word per pixel)
    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;

    // Default pixel word width
    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pixel_t;

    // Scan-out reader state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fb_state_e;

    // Width of an occupancy count that can represent 0..depth inclusive
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered head, occupancy count and flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    // A push into a full FIFO or a pop from an empty one is dropped
    always_comb begin
        do_push = push_i && (count_q != (AW+1)'(DEPTH));
        do_pop  = pop_i  && (count_q != '0);
    end

    // Storage, pointers and count; flush empties without touching storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fb_scanout_reader.sv
// Framebuffer scan-out reader: walks the framebuffer once per frame through
// an SRAM port with 1-cycle read latency and feeds a prefetch FIFO that the
// pixel pipeline pops with valid/ready.
// Optional: FB_READER_DOUBLE_BUFFER_EN adds buf_sel to pick one of two
// framebuffers, latched at frame_start.
module fb_scanout_reader
    import fb_pkg::*;
#(
    parameter int D_WIDTH    = 8,
    parameter int A_WIDTH    = 15,
    parameter int NUM_PIXELS = FB_PIXELS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
`ifdef FB_READER_DOUBLE_BUFFER_EN
    input  logic               buf_sel,
`endif
    output logic [A_WIDTH-1:0] sram_addr,
    output logic               sram_rd_en,
    input  logic [D_WIDTH-1:0] sram_rdata,
    output logic               pixel_valid,
    input  logic               pixel_ready,
    output logic [D_WIDTH-1:0] pixel_data,
    output logic               frame_done,
    output logic               underflow
);

    localparam int CW = fifo_cnt_w(FIFO_DEPTH);
    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(NUM_PIXELS - 1);

    fb_state_e          state_q, state_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic               rd_pending_q, rd_pending_d;
    logic               frame_done_q, frame_done_d;
    logic               underflow_q, underflow_d;

    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic [D_WIDTH-1:0] fifo_head;
    logic               pop;
    logic               issue;
    logic               last_issue;
    logic               drain_done;
    logic [CW:0]        occupancy;
    logic [CW:0]        issue_limit;

    assign pop = pixel_ready && !fifo_empty;

    // Issue when the slots committed (stored + in flight) stay within depth;
    // a same-cycle pop frees a slot. frame_start suppresses issue that cycle.
    always_comb begin
        occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pending_q};
        issue_limit = (CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop};
        issue       = (state_q == FETCH) && !frame_start && (occupancy < issue_limit);
        last_issue  = issue && (addr_q == LAST_ADDR);
        // Frame is finished once nothing is in flight and the FIFO is empty
        // after this cycle's pop, so frame_done lands the cycle after the
        // final pixel is taken.
        drain_done  = !rd_pending_q &&
                      (fifo_empty || ((fifo_count == CW'(1)) && pop));
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; frame_start restarts from any state
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = FETCH;
        end else begin
            unique case (state_q)
                IDLE:    state_d = IDLE;
                FETCH:   if (last_issue) state_d = DRAIN;
                DRAIN:   if (drain_done) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next state: address counter, in-flight flag, status flags
    always_comb begin
        addr_d       = addr_q;
        rd_pending_d = issue;
        frame_done_d = frame_done_q;
        underflow_d  = underflow_q;
        if (frame_start) begin
            addr_d       = '0;
            rd_pending_d = 1'b0;
            frame_done_d = 1'b0;
            underflow_d  = 1'b0;
        end else begin
            // Counter parks on the last address rather than running past it
            if (issue && !last_issue) addr_d = addr_q + A_WIDTH'(1);
            if ((state_q == DRAIN) && drain_done) frame_done_d = 1'b1;
            if ((state_q == FETCH) && pixel_ready && fifo_empty) underflow_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            rd_pending_q <= 1'b0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            rd_pending_q <= rd_pending_d;
            frame_done_q <= frame_done_d;
            underflow_q  <= underflow_d;
        end
    end

`ifdef FB_READER_DOUBLE_BUFFER_EN
    localparam logic [A_WIDTH-1:0] BUF1_BASE = A_WIDTH'(NUM_PIXELS);
    logic base_q, base_d;

    // Buffer select is latched only at frame start so a frame never tears
    always_comb begin
        base_d = frame_start ? buf_sel : base_q;
    end

    // Buffer select register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) base_q <= 1'b0;
        else        base_q <= base_d;
    end

    assign sram_addr = base_q ? (addr_q + BUF1_BASE) : addr_q;
`else
    assign sram_addr = addr_q;
`endif

    // Returned word is discarded when frame_start flushes in the same cycle
    sync_fifo #(
        .WIDTH (D_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_prefetch (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (frame_start),
        .push_i      (rd_pending_q),
        .push_data_i (sram_rdata),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign sram_rd_en  = issue;
    assign pixel_valid = !fifo_empty;
    assign pixel_data  = fifo_head;
    assign frame_done  = frame_done_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Directed self-checking bench for fb_scanout_reader (16-pixel frame).
module tb_fb_scanout_reader;
    import fb_pkg::*;

    localparam int DW = 8;
    localparam int AW = 15;
    localparam int NP = 16;
    localparam int FD = 4;

    logic          clk, rst_n, frame_start;
    logic          sram_rd_en, pixel_valid, pixel_ready, frame_done, underflow;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_rdata, pixel_data;
`ifdef FB_READER_DOUBLE_BUFFER_EN
    logic          buf_sel;
`endif

    int n_cmp, n_err;

    fb_scanout_reader #(
        .D_WIDTH(DW), .A_WIDTH(AW), .NUM_PIXELS(NP), .FIFO_DEPTH(FD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
`ifdef FB_READER_DOUBLE_BUFFER_EN
        .buf_sel     (buf_sel),
`endif
        .sram_addr   (sram_addr),
        .sram_rd_en  (sram_rd_en),
        .sram_rdata  (sram_rdata),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .pixel_data  (pixel_data),
        .frame_done  (frame_done),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: mem[i] = i & 0xFF, registered read
    always @(posedge clk) if (sram_rd_en) sram_rdata <= sram_addr[7:0];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (sram_addr !== '0)  begin n_err++; $display("FAIL reset_addr got=%0h want=0", sram_addr); end
        n_cmp++; if (sram_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got=%b want=0", sram_rd_en); end
        n_cmp++; if (pixel_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", pixel_valid); end
        n_cmp++; if (pixel_data !== '0) begin n_err++; $display("FAIL reset_data got=%0h want=0", pixel_data); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL reset_underflow got=%b want=0", underflow); end
    endtask

    // Whole frame: first issue cycle 1, first pixel cycle 3, 1 pixel/cycle,
    // last read addr 15, frame_done the cycle after the 16th pop.
    task automatic test_stream();
        frame_start = 1'b1; pixel_ready = 1'b0; #1;
        n_cmp++; if (sram_rd_en !== 1'b0) begin n_err++; $display("FAIL stream_fs_no_issue got=%b want=0", sram_rd_en); end
        for (int c = 1; c <= 21; c++) begin
            logic   e_rd, e_v, e_fd;
            pixel_t e_px;
            next_cycle();
            frame_start = 1'b0;
            pixel_ready = (c >= 3);
            #1;
            e_rd = (c <= 16);
            e_v  = (c >= 3) && (c <= 18);
            e_fd = (c >= 19);
            e_px = pixel_t'(c - 3);
            n_cmp++; if (sram_rd_en !== e_rd) begin n_err++; $display("FAIL stream_rd_en c=%0d got=%b want=%b", c, sram_rd_en, e_rd); end
            if (e_rd) begin
                n_cmp++; if (sram_addr !== AW'(c - 1)) begin n_err++; $display("FAIL stream_addr c=%0d got=%0d want=%0d", c, sram_addr, c - 1); end
            end
            n_cmp++; if (pixel_valid !== e_v) begin n_err++; $display("FAIL stream_valid c=%0d got=%b want=%b", c, pixel_valid, e_v); end
            if (e_v) begin
                n_cmp++; if (pixel_data !== e_px) begin n_err++; $display("FAIL stream_data c=%0d got=%0h want=%0h", c, pixel_data, e_px); end
            end
            n_cmp++; if (frame_done !== e_fd) begin n_err++; $display("FAIL stream_frame_done c=%0d got=%b want=%b", c, frame_done, e_fd); end
        end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL stream_underflow got=%b want=0", underflow); end
        pixel_ready = 1'b0;
    endtask

    // Consumer stalled: exactly 4 reads, then refill resumes at addr 4 on pop
    task automatic test_backpressure();
        next_cycle();
        frame_start = 1'b1; pixel_ready = 1'b0; #1;
        for (int c = 1; c <= 14; c++) begin
            logic              e_rd;
            logic [AW-1:0]     e_a;
            pixel_t            e_px;
            next_cycle();
            frame_start = 1'b0;
            pixel_ready = (c >= 9);
            #1;
            e_rd = (c <= 4) || (c >= 9);
            e_a  = (c <= 4) ? AW'(c - 1) : AW'(c - 5);
            e_px = pixel_t'(c - 9);
            if (c == 1) begin
                n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL bp_frame_done_clr got=%b want=0", frame_done); end
            end
            n_cmp++; if (sram_rd_en !== e_rd) begin n_err++; $display("FAIL bp_rd_en c=%0d got=%b want=%b", c, sram_rd_en, e_rd); end
            if (e_rd) begin
                n_cmp++; if (sram_addr !== e_a) begin n_err++; $display("FAIL bp_addr c=%0d got=%0d want=%0d", c, sram_addr, e_a); end
            end
            n_cmp++; if (pixel_valid !== (c >= 3)) begin n_err++; $display("FAIL bp_valid c=%0d got=%b want=%b", c, pixel_valid, (c >= 3)); end
            if (c >= 9) begin
                n_cmp++; if (pixel_data !== e_px) begin n_err++; $display("FAIL bp_data c=%0d got=%0h want=%0h", c, pixel_data, e_px); end
            end
        end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL bp_underflow got=%b want=0", underflow); end
        pixel_ready = 1'b0;
    endtask

    // Restart after pixel 7: next pixels restart at mem[0], nothing stale
    task automatic test_restart();
        next_cycle();
        frame_start = 1'b1; pixel_ready = 1'b0; #1;
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            frame_start = 1'b0;
            pixel_ready = (c >= 3);
            #1;
            if (c >= 3) begin
                n_cmp++; if (pixel_data !== pixel_t'(c - 3)) begin n_err++; $display("FAIL rs_pre_data c=%0d got=%0h want=%0h", c, pixel_data, c - 3); end
            end
        end
        next_cycle();
        frame_start = 1'b1; pixel_ready = 1'b0; #1;
        n_cmp++; if (sram_rd_en !== 1'b0) begin n_err++; $display("FAIL rs_fs_no_issue got=%b want=0", sram_rd_en); end
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            frame_start = 1'b0;
            pixel_ready = (c >= 3);
            #1;
            if (c == 1) begin
                n_cmp++; if (sram_rd_en !== 1'b1 || sram_addr !== '0) begin n_err++; $display("FAIL rs_first_issue got=%b/%0d want=1/0", sram_rd_en, sram_addr); end
            end
            n_cmp++; if (pixel_valid !== (c >= 3)) begin n_err++; $display("FAIL rs_valid c=%0d got=%b want=%b", c, pixel_valid, (c >= 3)); end
            if (c >= 3) begin
                n_cmp++; if (pixel_data !== pixel_t'(c - 3)) begin n_err++; $display("FAIL rs_data c=%0d got=%0h want=%0h", c, pixel_data, c - 3); end
            end
        end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL rs_underflow got=%b want=0", underflow); end
        pixel_ready = 1'b0;
    endtask

    // Ready high while FETCH FIFO is empty sets sticky underflow
    task automatic test_underflow();
        next_cycle();
        frame_start = 1'b1; pixel_ready = 1'b1; #1;
        next_cycle();
        frame_start = 1'b0; #1;
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL uf_cleared got=%b want=0", underflow); end
        next_cycle(); #1;
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_set got=%b want=1", underflow); end
        for (int c = 3; c <= 10; c++) begin
            next_cycle();
            pixel_ready = c[0];
            #1;
            n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky c=%0d got=%b want=1", c, underflow); end
        end
        next_cycle();
        frame_start = 1'b1; pixel_ready = 1'b0; #1;
        next_cycle();
        frame_start = 1'b0; #1;
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL uf_clear_fs got=%b want=0", underflow); end
    endtask

`ifdef FB_READER_DOUBLE_BUFFER_EN
    // Buffer 1 starts at NP; buf_sel changes mid-frame are ignored
    task automatic test_double_buffer();
        next_cycle();
        frame_start = 1'b1; buf_sel = 1'b1; pixel_ready = 1'b0; #1;
        next_cycle();
        frame_start = 1'b0; #1;
        n_cmp++; if (sram_rd_en !== 1'b1 || sram_addr !== AW'(NP)) begin n_err++; $display("FAIL db_first got=%b/%0d want=1/%0d", sram_rd_en, sram_addr, NP); end
        next_cycle();
        buf_sel = 1'b0; #1;
        n_cmp++; if (sram_addr !== AW'(NP + 1)) begin n_err++; $display("FAIL db_hold got=%0d want=%0d", sram_addr, NP + 1); end
        next_cycle(); #1;
        n_cmp++; if (pixel_data !== pixel_t'(NP)) begin n_err++; $display("FAIL db_data got=%0h want=%0h", pixel_data, NP); end
        next_cycle();
        frame_start = 1'b1; #1;
        next_cycle();
        frame_start = 1'b0; #1;
        n_cmp++; if (sram_addr !== '0) begin n_err++; $display("FAIL db_buf0 got=%0d want=0", sram_addr); end
    endtask
`endif

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; frame_start = 1'b0; pixel_ready = 1'b0;
`ifdef FB_READER_DOUBLE_BUFFER_EN
        buf_sel = 1'b0;
`endif
        #12;
        test_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        test_stream();
        test_backpressure();
        test_restart();
        test_underflow();
`ifdef FB_READER_DOUBLE_BUFFER_EN
        test_double_buffer();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
